// File: rtl/alu_issue_seq.sv
// Program buffer + issue sequencer feeding the pipelined 16-bit ALU, one instruction per 2-clock slot.
// Optional define HAZARD_INTERLOCK_EN inserts one bubble slot on a back-to-back read-after-write.
module alu_issue_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [23:0]   load_data,
  input  logic          clear,
  input  logic          start,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2,
  output logic [3:0]    rd,
  output logic [3:0]    func,
  output logic [7:0]    addr,
  output logic          issue_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [3:0]  FUNC_NOP = 4'hF;

  state_t      state;
  logic        phase;
  logic [AW:0] ip;
  instr_t      mem [DEPTH];
  instr_t      cur;

  logic        idle_like, wr, hazard, upd, fin, stall_now, do_issue, do_bubble;
  logic [AW:0] count_nxt;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign load_ready = idle_like && (count < FULL);
  assign wr         = load_valid && load_ready;
  assign count_nxt  = count + (AW+1)'(wr);
  assign cur        = mem[ip[AW-1:0]];

  // The ALU writes back on the same edge the next slot reads its bank, so a
  // dependent instruction directly behind a writer needs one slot of separation.
`ifdef HAZARD_INTERLOCK_EN
  assign hazard = issue_valid && (func <= 4'd11) && ((cur.rs1 == rd) || (cur.rs2 == rd));
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    upd       = phase && ((state == RUN) || (state == STALL));
    fin       = (state == RUN) && (ip == count);
    stall_now = (state == RUN) && !fin && hazard;
    do_issue  = upd && !fin && !stall_now;
    do_bubble = upd && (fin || stall_now);
  end

  // Buffer contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (wr) mem[count[AW-1:0]] <= instr_t'(load_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 1'b0;
      ip          <= '0;
      count       <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      addr        <= '0;
      func        <= FUNC_NOP;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      phase <= ~phase;
      if (wr) count <= count_nxt;

      if (do_issue) begin
        func        <= cur.func;
        rd          <= cur.rd;
        rs1         <= cur.rs1;
        rs2         <= cur.rs2;
        addr        <= cur.addr;
        issue_valid <= 1'b1;
        ip          <= ip + 1'b1;
      end
      // A bubble only kills func/valid; the register/address fields hold.
      if (do_bubble) begin
        func        <= FUNC_NOP;
        issue_valid <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (clear) begin
            count <= '0;
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            // count_nxt lets a same-cycle load count toward this run.
            if (count_nxt != '0) begin
              state <= RUN;
              ip    <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (upd) begin
            if (fin) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (stall_now) begin
              state <= STALL;
            end
          end
        end
        STALL: begin
          if (upd) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: load/run/hazard/full/clear/reset scenarios with hand-computed slots.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_ready, clear, start;
  logic [23:0] load_data;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid, busy, done;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  alu_issue_seq #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .clear(clear), .start(start),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // {func, rd, rs1, rs2, addr}
  localparam logic [23:0] W_ADD  = 24'h031210;  // r3 = r1 + r2
  localparam logic [23:0] W_SUB  = 24'h145611;  // r4 = r5 - r6
  localparam logic [23:0] W_XOR  = 24'h478912;  // r7 = r8 ^ r9
  localparam logic [23:0] W_AND  = 24'h253420;  // r5 = r3 & r4
  localparam logic [23:0] W_ONE  = 24'h6ABC33;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Advance to the first update edge (even edge count since reset release).
  task automatic to_update();
    tick();
    if (ncyc % 2 != 0) tick();
  endtask

  task automatic slot(input string tag, input logic [23:0] w, input logic v);
    chk({tag, ".func"}, 32'(func), v ? 32'(w[23:20]) : 32'hF);
    chk({tag, ".rd"},   32'(rd),   32'(w[19:16]));
    chk({tag, ".rs1"},  32'(rs1),  32'(w[15:12]));
    chk({tag, ".rs2"},  32'(rs2),  32'(w[11:8]));
    chk({tag, ".addr"}, 32'(addr), 32'(w[7:0]));
    chk({tag, ".vld"},  32'(issue_valid), 32'(v));
  endtask

  task automatic load(input logic [23:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; clear = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst.func", 32'(func), 32'hF);
    chk("rst.vld",  32'(issue_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.cnt",  32'(count), 0);
    chk("rst.rdy",  32'(load_ready), 1);
    chk("rst.fld",  32'({rs1, rs2, rd, addr}), 0);
    reset = 1'b0; ncyc = 0;

    // Three independent words; a start during RUN must be ignored.
    load(W_ADD); load(W_SUB); load(W_XOR);
    chk("ld3.cnt", 32'(count), 3);
    pulse_start();
    chk("run.busy", 32'(busy), 1);
    chk("run.done", 32'(done), 0);
    to_update();  slot("s0", W_ADD, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    slot("s0h", W_ADD, 1'b1);
    tick();       slot("s1", W_SUB, 1'b1);
    tick(); tick(); slot("s2", W_XOR, 1'b1);
    chk("s2.busy", 32'(busy), 1);
    tick(); tick(); slot("end", W_XOR, 1'b0);
    chk("end.done", 32'(done), 1);
    chk("end.busy", 32'(busy), 0);
    tick(); tick(); chk("end.hold", 32'(done), 1);
    chk("end.hvld", 32'(issue_valid), 0);

    // RAW pair: ADD writes r3, AND reads r3.
    do_clear();
    chk("clr.cnt",  32'(count), 0);
    chk("clr.done", 32'(done), 0);
    load(W_ADD); load(W_AND);
    pulse_start();
    to_update();  slot("h0", W_ADD, 1'b1);
`ifdef HAZARD_INTERLOCK_EN
    tick(); tick(); slot("hb", W_ADD, 1'b0);
    chk("hb.busy", 32'(busy), 1);
`endif
    tick(); tick(); slot("h1", W_AND, 1'b1);
    tick(); tick(); slot("hend", W_AND, 1'b0);
    chk("hend.done", 32'(done), 1);

    // Fill to DEPTH, then an extra write is dropped.
    do_clear();
    for (int i = 0; i < 16; i++) begin
      load({4'h0, 4'(i), 4'h1, 4'h2, 8'(i)});
      if (i == 14) chk("f15.rdy", 32'(load_ready), 1);
    end
    chk("f16.rdy", 32'(load_ready), 0);
    chk("f16.cnt", 32'(count), 16);
    load(24'hFFFFFF);
    chk("f17.cnt", 32'(count), 16);

    // Start with an empty buffer goes straight to DONE.
    do_clear();
    pulse_start();
    chk("e.done", 32'(done), 1);
    chk("e.busy", 32'(busy), 0);
    tick(); tick();
    chk("e.busy2", 32'(busy), 0);
    chk("e.vld",   32'(issue_valid), 0);

    // In DONE with a loaded word: clear beats start.
    load(W_SUB);
    chk("cs.cnt0", 32'(count), 1);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("cs.cnt",  32'(count), 0);
    chk("cs.busy", 32'(busy), 0);
    chk("cs.done", 32'(done), 0);
    tick(); tick(); tick();
    chk("cs.busy2", 32'(busy), 0);
    chk("cs.vld",   32'(issue_valid), 0);
    load(W_ONE);
    pulse_start();
    to_update();  slot("one", W_ONE, 1'b1);
    tick(); tick(); slot("oend", W_ONE, 1'b0);
    chk("oend.done", 32'(done), 1);

    // Load and start in the same cycle from an empty buffer.
    do_clear();
    load_valid = 1'b1; load_data = W_XOR; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    chk("ls.busy", 32'(busy), 1);
    chk("ls.cnt",  32'(count), 1);
    to_update();  slot("ls", W_XOR, 1'b1);
    tick(); tick(); chk("ls.done", 32'(done), 1);

    // Reset in the middle of a run.
    do_clear();
    load(W_ADD); load(W_SUB); load(W_XOR);
    pulse_start();
    to_update();  slot("m0", W_ADD, 1'b1);
    tick(); tick(); slot("m1", W_SUB, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("mr.func", 32'(func), 32'hF);
    chk("mr.vld",  32'(issue_valid), 0);
    chk("mr.busy", 32'(busy), 0);
    chk("mr.cnt",  32'(count), 0);
    chk("mr.fld",  32'({rs1, rs2, rd, addr}), 0);
    reset = 1'b0; ncyc = 0;
    tick();
    chk("mr.rdy",  32'(load_ready), 1);
    chk("mr.busy2", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Instruction sequencer that drives the instruction-side inputs (rs1, rs2, rd, func, addr) of the pipelined 16-bit ALU. Software/testbench first loads a short program into an internal buffer. A start pulse then makes the block issue one instruction per ALU slot, every 2 clocks, phase-aligned to the ALU's 2-bit ring counter. Optionally, the block inserts bubbles to avoid the ALU's back-to-back read-after-write hazard.

## Interface
- DEPTH, 16: program buffer entries (power of 2, 2..256).
- AW, 4: log2(DEPTH).
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; same reset net as the ALU.
- load_valid  input  1  program-word write request.
- load_ready  output  1  buffer can accept a word.
- load_data  input  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- clear  input  1  empties the buffer (count to 0); honoured only in IDLE/DONE.
- start  input  1  one-cycle pulse that begins issuing from entry 0.
- rs1, rs2, rd, func  output  4 each  ALU instruction fields.
- addr  output  8  ALU memory address field.
- issue_valid  output  1  current outputs are a real instruction, not a bubble.
- busy  output  1  high in RUN and STALL.
- done  output  1  high in DONE.
- count  output  AW+1  number of loaded words.

## Operation
- **Reset values:**
  - rs1, rs2, rd, addr: 0.
  - func: 4'hF (NOP/bubble encoding).
  - issue_valid, busy, done: 0.
  - count: 0; load_ready: 1.
  - FSM: IDLE; internal phase: 0.
  - Buffer contents are don't-care.
- **Load:**
  - load_ready = (state is IDLE or DONE) and count < DEPTH.
  - A word is written when load_valid and load_ready are both high. It goes to entry count, and count increments.
  - Writes are dropped when the buffer is full or while busy.
- **Phase:**
  - The phase bit toggles every clock, starting at 0 after reset.
  - Instruction outputs may change only on posedges where phase is 1. They then hold for 2 clocks.
  - This makes outputs stable one full cycle before each ALU stage-1 sampling edge (ring_out == 01).
- **FSM states:**
  - IDLE → RUN: on start with count > 0. Issue pointer ip is set to 0.
  - IDLE → DONE: on start with count == 0. No issue occurs.
  - RUN, at each update edge:
    - If ip == count, drive a bubble and go to DONE.
    - Else if a hazard exists (see Configuration), drive a bubble and go to STALL. ip is held.
    - Else drive entry[ip] with issue_valid = 1, and increment ip.
  - STALL: at the next update edge, drive entry[ip] with issue_valid = 1, increment ip, and return to RUN. One bubble per hazard.
  - DONE: outputs hold the bubble (func = F, issue_valid = 0). A start re-runs from entry 0 with the same program. clear sets count to 0 and returns to IDLE.
- **Bubble:** func = 4'hF, issue_valid = 0. rs1, rs2, rd and addr keep their previous values.
- **Ignored inputs:** start during RUN/STALL is ignored. clear during RUN/STALL is ignored.
- **Simultaneous events:**
  - start and clear in the same cycle in IDLE/DONE: clear wins and start is dropped.
  - load and start in the same cycle: the word is written and the run uses the new count.
- **Mid-run reset:** all outputs return to reset values immediately (asynchronously).

## Timing
- Issue rate: one slot per 2 clocks. A program of N words with no hazards completes in N slots, plus one bubble slot on entry to DONE.
- Latency from start: start is sampled at posedge t; the first instruction is driven at the first phase-1 update edge after t (t+1 or t+2).
- busy deasserts and done asserts on the same edge as the final bubble.
- A hazard costs exactly one 2-clock slot.

## Configuration
- **HAZARD_INTERLOCK_EN:**
  - Defined: a hazard exists when the previously issued slot was valid, its func ≤ 11, and (entry[ip].rs1 == prev_rd or entry[ip].rs2 == prev_rd). A bubble is inserted, because the ALU writes back on the same edge the next instruction reads its register bank.
  - Undefined: no hazard check. STALL is unreachable. Instructions issue back-to-back every slot.

## Test plan
- Reset mid-run after 2 issues → func = F, issue_valid = 0, busy = 0, count = 0 immediately. load_ready = 1 on the next cycle.
- Load 3 independent words (ADD r3=r1+r2, SUB r4=r5-r6, XOR r7=r8^r9), then start → 3 valid slots 2 clocks apart, fields match the words, then a bubble with done = 1.
- With HAZARD_INTERLOCK_EN: load ADD r3=r1+r2, then AND r5=r3&r4, then start → ADD slot, one bubble slot, AND slot; the run is one slot longer. Without the macro: no bubble.
- Load 16 words with DEPTH = 16 → load_ready drops after the 16th write; a 17th load_valid is dropped and count stays 16.
- start with count = 0 → busy never asserts, done = 1 on the next cycle. start pulsed during RUN → ignored, ip unaffected.
- In DONE, assert clear and start together → count = 0, IDLE, no issue. Then load 1 word and start → exactly one valid slot.
